ex_stage_pipe: RTL and testbench
================================

EX_STAGE_PIPE -- requirements
Module: ex_stage_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width in bits (legal 8..128).
REQ-002 SHALL have parameter BR_SHIFT, default 2, left-shift applied to the immediate for the branch target.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  in  1  upstream operands valid.
REQ-006 SHALL have port in_ready  out  1  stage accepts operands this cycle.
REQ-007 SHALL have ports in_pc, in_imm, in_rs1, in_rs2  in  XLEN each  PC, sign-extended immediate, register operands.
REQ-008 SHALL have ports in_alu_src  in  1; in_alu_op  in  2; in_func  in  4  operand select, ALUOp, {funct7[5], funct3}.
REQ-009 SHALL have port in_ctrl  in  5  {reg_write, mem_to_reg, mem_write, mem_read, branch}.
REQ-010 SHALL have port flush  in  1  kill in-flight and held work.
REQ-011 SHALL have ports out_valid  out  1; out_ready  in  1  downstream handshake.
REQ-012 SHALL have ports out_result, out_rs2, out_pcbranch  out  XLEN each  ALU result, forwarded store data, branch target.
REQ-013 SHALL have ports out_zero, out_taken  out  1 each; out_ctrl  out  5  registered control.

Function
REQ-014 SHALL transfer an input when in_valid && in_ready; in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
REQ-015 SHALL select ALU operand B = in_imm when in_alu_src=1, else in_rs2.
REQ-016 SHALL decode ALUOp 00 -> add, 01 -> sub, 10 -> by in_func: 0000 add, 1000 sub, 0111 and, 0110 or; other func -> add.
REQ-017 SHALL compute all arithmetic modulo 2^XLEN; overflow discarded.
REQ-018 SHALL compute out_pcbranch = in_pc + (in_imm << BR_SHIFT), truncated to XLEN.
REQ-019 SHALL set out_zero = (out_result == 0) and out_taken = branch bit of out_ctrl && out_zero.
REQ-020 SHALL, for non-multiply ops, load the output register on the cycle after acceptance (latency 1, throughput 1/cycle when out_ready held 1).
REQ-021 SHALL hold out_* stable while out_valid && !out_ready; clear out_valid on out_ready when no new result loads.
REQ-022 SHALL implement FSM IDLE -> BUSY (multiply accepted) -> IDLE (count reached XLEN, result loaded to output register).
REQ-023 SHALL, on flush, clear out_valid and return FSM to IDLE on the same edge; flush overrides a simultaneous accept and completion.
REQ-024 SHALL, on simultaneous out_ready and new load, replace the output register without a bubble.

Reset
REQ-025 SHALL, on rst, set out_valid=0, FSM=IDLE, multiply counter=0, all out_* data/control=0; in_ready=1 first cycle after rst deasserts.
REQ-026 SHALL give rst priority over flush and all handshakes, including mid-multiply.

Configuration
REQ-027 SHALL, with EX_STAGE_MUL_EN defined, execute ALUOp 11 as unsigned iterative shift-add multiply, low XLEN bits, latency XLEN+1 cycles, in_ready=0 while BUSY.
REQ-028 SHALL, without EX_STAGE_MUL_EN, treat ALUOp 11 as add with latency 1; FSM never leaves IDLE.

Structure
REQ-029 SHALL place ALU operation codes (and 0000, or 0001, add 0010, sub 0110), ALUOp encodings, in_ctrl bit indices and FSM state type in shared package ex_pkg.
REQ-030 SHALL instantiate one combinational sub-module ex_alu (XLEN-parametrised, operands + operation code -> result); multiplier and handshake logic stay in ex_stage_pipe.

Verification
REQ-031 SHALL cover: XLEN=64, ALUOp=10, func=1000, rs1=5, rs2=5 -> next cycle out_result=0, out_zero=1; with branch=1, out_taken=1.
REQ-032 SHALL cover: in_pc=0x100, in_imm=0xFFFF_FFFF_FFFF_FFFC (-4), BR_SHIFT=2 -> out_pcbranch=0xF0.
REQ-033 SHALL cover: out_ready=0 for 3 cycles after a valid result -> out_* unchanged, in_ready=0; out_ready=1 -> queued op loads next cycle.
REQ-034 SHALL cover: EX_STAGE_MUL_EN, rs1=7, rs2=6, ALUOp=11 -> in_ready=0 for 64 cycles, out_result=42, out_valid at cycle 65.
REQ-035 SHALL cover: flush asserted on cycle 10 of a multiply -> out_valid stays 0, FSM IDLE, in_ready=1 next cycle.
REQ-036 SHALL cover: rst asserted with out_valid=1 -> all outputs 0 on next edge; XLEN=32 add 0xFFFF_FFFF+1 -> out_result=0.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU operation codes, ALUOp field values,
// in_ctrl bit positions and the multiply sequencer state type.
package ex_pkg;

   typedef enum logic [3:0] {
      AluAnd = 4'b0000,
      AluOr  = 4'b0001,
      AluAdd = 4'b0010,
      AluSub = 4'b0110
   } alu_op_e;

   localparam logic [1:0] AluOpAdd  = 2'b00;
   localparam logic [1:0] AluOpSub  = 2'b01;
   localparam logic [1:0] AluOpFunc = 2'b10;
   localparam logic [1:0] AluOpMul  = 2'b11;

   // in_ctrl = {reg_write, mem_to_reg, mem_write, mem_read, branch}
   localparam int unsigned CtrlBranch   = 0;
   localparam int unsigned CtrlMemRead  = 1;
   localparam int unsigned CtrlMemWrite = 2;
   localparam int unsigned CtrlMemToReg = 3;
   localparam int unsigned CtrlRegWrite = 4;
   localparam int unsigned CtrlW        = 5;

   typedef enum logic {
      StIdle,
      StBusy
   } state_e;

   // func = {funct7[5], funct3}; unknown combinations fall back to add.
   function automatic alu_op_e decode_alu(input logic [1:0] alu_op, input logic [3:0] func);
      alu_op_e op;
      op = AluAdd;
      case (alu_op)
         AluOpSub: op = AluSub;
         AluOpFunc: begin
            case (func)
               4'b1000: op = AluSub;
               4'b0111: op = AluAnd;
               4'b0110: op = AluOr;
               default: op = AluAdd;
            endcase
         end
         default: op = AluAdd;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/ex_alu.sv
// Combinational ALU for the execute stage: two XLEN operands and an operation code in,
// result out. Arithmetic wraps modulo 2^XLEN.
module ex_alu
   import ex_pkg::*;
#(
   parameter int unsigned XLEN = 64
) (
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  alu_op_e         op,
   output logic [XLEN-1:0] result
);

   always_comb begin
      result = a + b;
      unique case (op)
         AluAnd:  result = a & b;
         AluOr:   result = a | b;
         AluSub:  result = a - b;
         default: result = a + b;
      endcase
   end

endmodule

// File: rtl/ex_stage_pipe.sv
// Execute pipeline stage with valid/ready handshake and a registered output slot.
// Define EX_STAGE_MUL_EN to run ALUOp 11 as an iterative shift-add multiply.
module ex_stage_pipe
   import ex_pkg::*;
#(
   parameter int unsigned XLEN     = 64,
   parameter int unsigned BR_SHIFT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  in_pc,
   input  logic [XLEN-1:0]  in_imm,
   input  logic [XLEN-1:0]  in_rs1,
   input  logic [XLEN-1:0]  in_rs2,
   input  logic             in_alu_src,
   input  logic [1:0]       in_alu_op,
   input  logic [3:0]       in_func,
   input  logic [CtrlW-1:0] in_ctrl,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_result,
   output logic [XLEN-1:0]  out_rs2,
   output logic [XLEN-1:0]  out_pcbranch,
   output logic             out_zero,
   output logic             out_taken,
   output logic [CtrlW-1:0] out_ctrl
);

   state_e            state_q, state_d;
   logic              out_valid_q, out_valid_d;
   logic [XLEN-1:0]   out_result_q, out_rs2_q, out_pcbranch_q;
   logic              out_zero_q, out_taken_q;
   logic [CtrlW-1:0]  out_ctrl_q;

   logic [XLEN-1:0]   op_b, alu_res, pcb_in, imm_sh;
   logic              accept, load, ld_zero;
   logic [XLEN-1:0]   ld_result, ld_rs2, ld_pcb;
   logic [CtrlW-1:0]  ld_ctrl;

   assign op_b   = in_alu_src ? in_imm : in_rs2;
   assign imm_sh = in_imm << BR_SHIFT;
   assign pcb_in = in_pc + imm_sh;

   ex_alu #(
      .XLEN (XLEN)
   ) u_alu (
      .a      (in_rs1),
      .b      (op_b),
      .op     (decode_alu(in_alu_op, in_func)),
      .result (alu_res)
   );

   assign in_ready = (state_q == StIdle) && (!out_valid_q || out_ready) && !flush;
   assign accept   = in_valid && in_ready;

`ifdef EX_STAGE_MUL_EN
   localparam int unsigned CntW = $clog2(XLEN + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);

   logic [CntW-1:0]  cnt_q;
   logic [XLEN-1:0]  mcand_q, mplier_q, acc_q, acc_nxt;
   logic [XLEN-1:0]  hold_rs2_q, hold_pcb_q;
   logic [CtrlW-1:0] hold_ctrl_q;

   // One multiplier bit per cycle; the final step's sum feeds the output slot directly.
   assign acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q && !out_ready;
      load        = 1'b0;
      ld_result   = alu_res;
      ld_rs2      = in_rs2;
      ld_pcb      = pcb_in;
      ld_ctrl     = in_ctrl;
      if (state_q == StIdle) begin
         if (accept) begin
`ifdef EX_STAGE_MUL_EN
            if (in_alu_op == AluOpMul) begin
               state_d = StBusy;
            end else begin
               load = 1'b1;
            end
`else
            load = 1'b1;
`endif
         end
      end else begin
`ifdef EX_STAGE_MUL_EN
         if (cnt_q == CntLast) begin
            load      = 1'b1;
            ld_result = acc_nxt;
            ld_rs2    = hold_rs2_q;
            ld_pcb    = hold_pcb_q;
            ld_ctrl   = hold_ctrl_q;
            state_d   = StIdle;
         end
`else
         state_d = StIdle;
`endif
      end
      if (load) begin
         out_valid_d = 1'b1;
      end
      // Flush kills both a fresh accept and a multiply completing on this edge.
      if (flush) begin
         out_valid_d = 1'b0;
         state_d     = StIdle;
         load        = 1'b0;
      end
   end

   assign ld_zero = (ld_result == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= StIdle;
         out_valid_q    <= 1'b0;
         out_result_q   <= '0;
         out_rs2_q      <= '0;
         out_pcbranch_q <= '0;
         out_zero_q     <= 1'b0;
         out_taken_q    <= 1'b0;
         out_ctrl_q     <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         if (load) begin
            out_result_q   <= ld_result;
            out_rs2_q      <= ld_rs2;
            out_pcbranch_q <= ld_pcb;
            out_zero_q     <= ld_zero;
            out_taken_q    <= ld_ctrl[CtrlBranch] && ld_zero;
            out_ctrl_q     <= ld_ctrl;
         end
      end
   end

`ifdef EX_STAGE_MUL_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         acc_q       <= '0;
         hold_rs2_q  <= '0;
         hold_pcb_q  <= '0;
         hold_ctrl_q <= '0;
      end else if (flush) begin
         cnt_q <= '0;
      end else if (state_q == StIdle) begin
         if (accept && (in_alu_op == AluOpMul)) begin
            mcand_q     <= in_rs1;
            mplier_q    <= op_b;
            acc_q       <= '0;
            cnt_q       <= '0;
            hold_rs2_q  <= in_rs2;
            hold_pcb_q  <= pcb_in;
            hold_ctrl_q <= in_ctrl;
         end
      end else begin
         acc_q    <= acc_nxt;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
      end
   end
`endif

   assign out_valid    = out_valid_q;
   assign out_result   = out_result_q;
   assign out_rs2      = out_rs2_q;
   assign out_pcbranch = out_pcbranch_q;
   assign out_zero     = out_zero_q;
   assign out_taken    = out_taken_q;
   assign out_ctrl     = out_ctrl_q;

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Randomised bench for ex_stage_pipe against a transaction-level reference model, plus
// directed cases for branch target, stalls, reset and (with EX_STAGE_MUL_EN) multiply.
module tb_ex_stage_pipe;

   localparam int unsigned XLEN = 64;

   typedef struct packed {
      logic [63:0] result;
      logic [63:0] rs2;
      logic [63:0] pcb;
      logic        zero;
      logic        taken;
      logic [4:0]  ctrl;
   } res_t;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_alu_src, flush, out_ready;
   logic [63:0] in_pc, in_imm, in_rs1, in_rs2;
   logic [1:0]  in_alu_op;
   logic [3:0]  in_func;
   logic [4:0]  in_ctrl;
   logic        in_ready, out_valid, out_zero, out_taken;
   logic [63:0] out_result, out_rs2, out_pcbranch;
   logic [4:0]  out_ctrl;

   logic        in_ready32, out_valid32, out_zero32, out_taken32;
   logic [31:0] out_result32, out_rs2_32, out_pcbranch32;
   logic [4:0]  out_ctrl32;

   int n_checks = 0;
   int n_fail   = 0;

   res_t m_out, m_pend;
   logic m_valid;
   int   m_busy;
   int   busy;

   always #5 clk = ~clk;

   ex_stage_pipe #(.XLEN(64), .BR_SHIFT(2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_alu_src(in_alu_src), .in_alu_op(in_alu_op), .in_func(in_func), .in_ctrl(in_ctrl),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_rs2(out_rs2), .out_pcbranch(out_pcbranch),
      .out_zero(out_zero), .out_taken(out_taken), .out_ctrl(out_ctrl)
   );

   ex_stage_pipe #(.XLEN(32), .BR_SHIFT(2)) dut32 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
      .in_pc(in_pc[31:0]), .in_imm(in_imm[31:0]), .in_rs1(in_rs1[31:0]),
      .in_rs2(in_rs2[31:0]), .in_alu_src(in_alu_src), .in_alu_op(in_alu_op),
      .in_func(in_func), .in_ctrl(in_ctrl), .flush(flush), .out_valid(out_valid32),
      .out_ready(out_ready), .out_result(out_result32), .out_rs2(out_rs2_32),
      .out_pcbranch(out_pcbranch32), .out_zero(out_zero32), .out_taken(out_taken32),
      .out_ctrl(out_ctrl32)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit is_mul_op(input logic [1:0] op);
`ifdef EX_STAGE_MUL_EN
      return op == 2'b11;
`else
      return 1'b0 && (op == 2'b11);
`endif
   endfunction

   // Expected transaction result straight from the operation table.
   function automatic res_t model_op();
      res_t        r;
      logic [63:0] b;
      b = in_alu_src ? in_imm : in_rs2;
      case (in_alu_op)
         2'b00: r.result = in_rs1 + b;
         2'b01: r.result = in_rs1 - b;
         2'b10: begin
            if (in_func == 4'b1000)      r.result = in_rs1 - b;
            else if (in_func == 4'b0111) r.result = in_rs1 & b;
            else if (in_func == 4'b0110) r.result = in_rs1 | b;
            else                         r.result = in_rs1 + b;
         end
         default: r.result = is_mul_op(in_alu_op) ? in_rs1 * b : in_rs1 + b;
      endcase
      r.rs2   = in_rs2;
      r.pcb   = in_pc + in_imm * 64'd4;
      r.zero  = (r.result == 64'd0);
      r.taken = in_ctrl[0] && r.zero;
      r.ctrl  = in_ctrl;
      return r;
   endfunction

   // Called at a negedge with inputs already driven; returns at the next negedge.
   task automatic step();
      logic exp_ready;
      #1;
      exp_ready = (m_busy == 0) && (!m_valid || out_ready) && !flush;
      check_eq("in_ready", in_ready, exp_ready);
      check_eq("out_valid", out_valid, m_valid);
      check_eq("out_result", out_result, m_out.result);
      check_eq("out_rs2", out_rs2, m_out.rs2);
      check_eq("out_pcbranch", out_pcbranch, m_out.pcb);
      check_eq("out_zero", out_zero, m_out.zero);
      check_eq("out_taken", out_taken, m_out.taken);
      check_eq("out_ctrl", out_ctrl, m_out.ctrl);
      @(posedge clk);
      if (rst) begin
         m_valid = 1'b0;
         m_busy  = 0;
         m_out   = '0;
      end else if (flush) begin
         m_valid = 1'b0;
         m_busy  = 0;
      end else begin
         if (out_ready) m_valid = 1'b0;
         if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
               m_out   = m_pend;
               m_valid = 1'b1;
            end
         end else if (in_valid && exp_ready) begin
            if (is_mul_op(in_alu_op)) begin
               m_pend = model_op();
               m_busy = XLEN;
            end else begin
               m_out   = model_op();
               m_valid = 1'b1;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic drive(input logic [1:0] op, input logic [3:0] func, input logic [63:0] rs1,
                        input logic [63:0] rs2, input logic [63:0] imm, input logic [63:0] pc,
                        input logic src, input logic [4:0] ctrl);
      in_valid   = 1'b1;
      in_alu_op  = op;
      in_func    = func;
      in_rs1     = rs1;
      in_rs2     = rs2;
      in_imm     = imm;
      in_pc      = pc;
      in_alu_src = src;
      in_ctrl    = ctrl;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      in_pc = '0; in_imm = '0; in_rs1 = '0; in_rs2 = '0;
      in_alu_src = 1'b0; in_alu_op = '0; in_func = '0; in_ctrl = '0;
      m_valid = 1'b0; m_busy = 0; m_out = '0; m_pend = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_eq("reset_in_ready", in_ready, 1);
      check_eq("reset_out_valid", out_valid, 0);
      step();

      // sub to zero sets zero and taken
      drive(2'b10, 4'b1000, 64'd5, 64'd5, 64'd0, 64'd0, 1'b0, 5'b00001);
      step();
      in_valid = 1'b0;
      check_eq("sub_zero_result", out_result, 0);
      check_eq("sub_zero_flag", out_zero, 1);
      check_eq("sub_zero_taken", out_taken, 1);

      // branch target with negative immediate
      drive(2'b00, 4'b0000, 64'd3, 64'd4, 64'hFFFF_FFFF_FFFF_FFFC, 64'h100, 1'b0, 5'b10000);
      step();
      in_valid = 1'b0;
      check_eq("pcbranch_neg", out_pcbranch, 64'hF0);

      // backpressure: hold result 30 for three cycles, then queued op loads
      drive(2'b00, 4'b0000, 64'd10, 64'd20, 64'd0, 64'd0, 1'b0, 5'b10000);
      step();
      out_ready = 1'b0;
      drive(2'b00, 4'b0000, 64'd1, 64'd2, 64'd0, 64'd0, 1'b0, 5'b10000);
      repeat (3) begin
         #1;
         check_eq("stall_in_ready", in_ready, 0);
         step();
         check_eq("stall_hold", out_result, 64'd30);
      end
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      check_eq("queued_result", out_result, 64'd3);
      check_eq("queued_valid", out_valid, 1);

      // reset while holding a valid result
      out_ready = 1'b0;
      drive(2'b10, 4'b0110, 64'hF0, 64'h0F, 64'd9, 64'h40, 1'b0, 5'b11111);
      step();
      in_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      out_ready = 1'b1;
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_out_result", out_result, 0);
      check_eq("rst_out_rs2", out_rs2, 0);
      check_eq("rst_out_pcbranch", out_pcbranch, 0);
      check_eq("rst_out_zero", out_zero, 0);
      check_eq("rst_out_taken", out_taken, 0);
      check_eq("rst_out_ctrl", out_ctrl, 0);
      #1;
      check_eq("rst_in_ready", in_ready, 1);

      // 32-bit wraparound alongside the 64-bit carry
      drive(2'b00, 4'b0000, 64'hFFFF_FFFF, 64'd1, 64'd0, 64'd0, 1'b0, 5'b00001);
      #1;
      check_eq("x32_in_ready", in_ready32, 1);
      step();
      in_valid = 1'b0;
      check_eq("x32_valid", out_valid32, 1);
      check_eq("x32_result", out_result32, 0);
      check_eq("x32_zero", out_zero32, 1);
      check_eq("x32_taken", out_taken32, 1);
      check_eq("x32_rs2", out_rs2_32, 1);
      check_eq("x32_pcbranch", out_pcbranch32, 0);
      check_eq("x32_ctrl", out_ctrl32, 5'b00001);
      check_eq("x64_carry", out_result, 64'h1_0000_0000);

`ifdef EX_STAGE_MUL_EN
      drive(2'b11, 4'b0000, 64'd7, 64'd6, 64'd0, 64'd0, 1'b0, 5'b10000);
      step();
      in_valid = 1'b0;
      busy = 0;
      for (int i = 0; i < 100; i++) begin
         #1;
         if (in_ready) break;
         busy++;
         step();
      end
      check_eq("mul_busy_cycles", busy, 64);
      check_eq("mul_valid", out_valid, 1);
      check_eq("mul_result", out_result, 64'd42);
      step();

      drive(2'b11, 4'b0000, 64'd3, 64'd5, 64'd0, 64'd0, 1'b0, 5'b10000);
      step();
      in_valid = 1'b0;
      repeat (9) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      #1;
      check_eq("flush_out_valid", out_valid, 0);
      check_eq("flush_in_ready", in_ready, 1);
      repeat (70) step();
`endif

      for (int c = 0; c < 600; c++) begin
         in_valid   = ($urandom_range(0, 3) != 0);
         out_ready  = ($urandom_range(0, 3) != 0);
         flush      = ($urandom_range(0, 31) == 0);
         in_alu_op  = 2'($urandom_range(0, 3));
`ifdef EX_STAGE_MUL_EN
         if (in_alu_op == 2'b11 && $urandom_range(0, 7) != 0) in_alu_op = 2'b00;
`endif
         case ($urandom_range(0, 4))
            0:       in_func = 4'b0000;
            1:       in_func = 4'b1000;
            2:       in_func = 4'b0111;
            3:       in_func = 4'b0110;
            default: in_func = 4'($urandom);
         endcase
         in_rs1     = ($urandom_range(0, 3) == 0) ? in_rs2 : {$urandom, $urandom};
         in_rs2     = {$urandom, $urandom};
         in_imm     = {$urandom, $urandom};
         in_pc      = {$urandom, $urandom};
         in_alu_src = 1'($urandom);
         in_ctrl    = 5'($urandom);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
